// File: rtl/wbuf_drain_serializer.sv
// Write-buffer drain stage: reads the selected cache-line entry, serializes it
// into BURST_LEN beats on a valid/ready DQ port, then pulses a release for it.
module wbuf_drain_serializer #(
    parameter int NUM_ENTRIES = 8,
    parameter int IDX_W       = 8,
    parameter int DQ_WIDTH    = 64,
    parameter int BURST_LEN   = 8,
    parameter int DATA_WIDTH  = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel_valid,
    input  logic [IDX_W-1:0]      sel_index,
    output logic [IDX_W-1:0]      rd_index,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  dq_valid,
    input  logic                  dq_ready,
    output logic [DQ_WIDTH-1:0]   dq_data,
    output logic                  dq_last,
    output logic                  release_valid,
    output logic [IDX_W-1:0]      release_index,
    output logic                  busy
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [IDX_W:0]    ENTRY_LIMIT = (IDX_W + 1)'(NUM_ENTRIES);

    if (DATA_WIDTH != BURST_LEN * DQ_WIDTH) begin : g_bad_width
        $error("wbuf_drain_serializer: DATA_WIDTH must equal BURST_LEN*DQ_WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_BURST   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      cur_idx_q, cur_idx_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      rd_index_q, rd_index_d;
    logic                  dq_valid_q, dq_valid_d;
    logic                  dq_last_q, dq_last_d;
    logic                  release_valid_q, release_valid_d;
    logic [IDX_W-1:0]      release_index_q, release_index_d;
    logic                  busy_q, busy_d;
    logic                  beat_accept;

    // Handshake: a beat transfers on a rising edge where dq_valid && dq_ready.
    // Once dq_valid is raised, dq_data/dq_last hold until that transfer.
    assign beat_accept = dq_valid_q && dq_ready;

    always_comb begin
        state_d         = state_q;
        cur_idx_d       = cur_idx_q;
        beat_d          = beat_q;
        shift_d         = shift_q;
        rd_index_d      = rd_index_q;
        dq_valid_d      = dq_valid_q;
        dq_last_d       = dq_last_q;
        release_valid_d = 1'b0;
        release_index_d = release_index_q;
        busy_d          = busy_q;

        case (state_q)
            ST_IDLE: begin
                rd_index_d = '0;
                if (sel_valid && ({1'b0, sel_index} < ENTRY_LIMIT)) begin
                    cur_idx_d  = sel_index;
                    rd_index_d = sel_index;
                    busy_d     = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // rd_index has been presenting cur_idx for this whole cycle.
                shift_d    = rd_data;
                beat_d     = '0;
                dq_valid_d = 1'b1;
                dq_last_d  = (LAST_BEAT == '0);
                state_d    = ST_BURST;
            end
            ST_BURST: begin
                if (beat_accept) begin
                    if (beat_q == LAST_BEAT) begin
                        dq_valid_d      = 1'b0;
                        dq_last_d       = 1'b0;
                        shift_d         = '0;
                        release_valid_d = 1'b1;
                        release_index_d = cur_idx_q;
                        state_d         = ST_RELEASE;
                    end else begin
                        beat_d    = beat_q + BEAT_W'(1);
                        shift_d   = shift_q >> DQ_WIDTH;
                        dq_last_d = ((beat_q + BEAT_W'(1)) == LAST_BEAT);
                    end
                end
            end
            ST_RELEASE: begin
                // The buffer frees the entry on this edge, so IDLE sees the new vector.
                release_index_d = '0;
                rd_index_d      = '0;
                busy_d          = 1'b0;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cur_idx_q       <= '0;
            beat_q          <= '0;
            shift_q         <= '0;
            rd_index_q      <= '0;
            dq_valid_q      <= 1'b0;
            dq_last_q       <= 1'b0;
            release_valid_q <= 1'b0;
            release_index_q <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_idx_q       <= cur_idx_d;
            beat_q          <= beat_d;
            shift_q         <= shift_d;
            rd_index_q      <= rd_index_d;
            dq_valid_q      <= dq_valid_d;
            dq_last_q       <= dq_last_d;
            release_valid_q <= release_valid_d;
            release_index_q <= release_index_d;
            busy_q          <= busy_d;
        end
    end

    assign rd_index      = rd_index_q;
    assign dq_valid      = dq_valid_q;
    assign dq_data       = shift_q[DQ_WIDTH-1:0];
    assign dq_last       = dq_last_q;
    assign release_valid = release_valid_q;
    assign release_index = release_index_q;
    assign busy          = busy_q;

endmodule
